// File: rtl/display_scan_ctrl_if.sv
// Frame producer link into the display scanner: symbols plus blink mask.
// Latency: n/a (wires only).
// Backpressure: frame_ready low while the scanner already holds a pending frame.
//   master: frame_valid, frame_data[11:0], blink_mask[3:0] out; frame_ready in
//   slave : the mirror image
interface display_scan_ctrl_if;
  logic        frame_valid;
  logic [11:0] frame_data;
  logic [3:0]  blink_mask;
  logic        frame_ready;

  modport master (
    output frame_valid,
    output frame_data,
    output blink_mask,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  frame_data,
    input  blink_mask,
    output frame_ready
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// 4-digit 7-segment scan controller with double-buffered, tear-free frame updates and per-digit blink.
// Latency: outputs registered, 1 cycle; an accepted frame is shown from the next frame boundary.
// Backpressure: frame_ready = pending buffer empty; it reopens the cycle after a commit.
//   clk, rst_n          : clock, async active-low reset
//   enable              : 1 scans, 0 blanks the display and freezes all counters
//   frm (slave)         : frame_valid/frame_ready handshake, frame_data, blink_mask
//   sel_num, sel_pos    : symbol (4 = blank) and digit index for the segment decoder
//   anode_n             : active-low digit enables
//   frame_start         : one-cycle pulse on the edge sel_pos wraps to 0
module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  display_scan_ctrl_if.slave         frm,
  output logic [2:0]                 sel_num,
  output logic [1:0]                 sel_pos,
  output logic [3:0]                 anode_n,
  output logic                       frame_start
);

  localparam int PW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [2:0]    SYM_BLANK  = 3'd4;

  typedef struct packed {
    logic [3:0]  mask;
    logic [11:0] syms;
  } frame_t;

  localparam frame_t FRAME_BLANK = '{mask: 4'b0000, syms: 12'b100_100_100_100};

  // Scan / blink state
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    pos_q, pos_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  // Double buffer
  frame_t        act_q, act_d;
  frame_t        pend_q, pend_d;
  logic          pend_full_q, pend_full_d;

  // Output registers
  logic [3:0]    anode_n_q, anode_n_d;
  logic [2:0]    sel_num_q, sel_num_d;
  logic [1:0]    sel_pos_q, sel_pos_d;
  logic          frame_start_q, frame_start_d;

  logic          tc;
  logic          boundary;
  logic          commit;
  logic          accept;

  function automatic logic [2:0] sym_at(input logic [11:0] syms, input logic [1:0] p);
    logic [2:0] s;
    case (p)
      2'd0:    s = syms[2:0];
      2'd1:    s = syms[5:3];
      2'd2:    s = syms[8:6];
      default: s = syms[11:9];
    endcase
    return s;
  endfunction

  always_comb begin
    presc_d       = presc_q;
    pos_d         = pos_q;
    bcnt_d        = bcnt_q;
    phase_d       = phase_q;
    act_d         = act_q;
    pend_d        = pend_q;
    pend_full_d   = pend_full_q;
    anode_n_d     = 4'b1111;
    sel_num_d     = SYM_BLANK;
    sel_pos_d     = pos_q;
    frame_start_d = 1'b0;

    tc       = enable && (presc_q == PRESC_LAST);
    boundary = tc && (pos_q == 2'd3);

    if (enable) begin
      if (tc) begin
        presc_d = '0;
        pos_d   = pos_q + 2'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
      if (boundary) begin
        if (bcnt_q == BLINK_LAST) begin
          bcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          bcnt_d  = bcnt_q + BW'(1);
        end
      end
    end

    // While dark there is no tearing to avoid, so a pending frame lands at once.
    commit = pend_full_q && (boundary || !enable);
    // Accept is gated on an empty buffer, so it can never collide with a commit.
    accept = frm.frame_valid && !pend_full_q;

    if (commit) begin
      act_d       = pend_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d      = '{mask: frm.blink_mask, syms: frm.frame_data};
      pend_full_d = 1'b1;
    end

    // Outputs are built from next-state values so the boundary edge already
    // shows digit 0 of the freshly committed frame in the new blink phase.
    sel_pos_d = pos_d;
    if (enable) begin
      anode_n_d     = ~(4'b0001 << pos_d);
      sel_num_d     = (phase_d && act_d.mask[pos_d]) ? SYM_BLANK : sym_at(act_d.syms, pos_d);
      frame_start_d = boundary;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      pos_q         <= 2'd0;
      bcnt_q        <= '0;
      phase_q       <= 1'b0;
      act_q         <= FRAME_BLANK;
      pend_q        <= FRAME_BLANK;
      pend_full_q   <= 1'b0;
      anode_n_q     <= 4'b1111;
      sel_num_q     <= SYM_BLANK;
      sel_pos_q     <= 2'd0;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      pos_q         <= pos_d;
      bcnt_q        <= bcnt_d;
      phase_q       <= phase_d;
      act_q         <= act_d;
      pend_q        <= pend_d;
      pend_full_q   <= pend_full_d;
      anode_n_q     <= anode_n_d;
      sel_num_q     <= sel_num_d;
      sel_pos_q     <= sel_pos_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frm.frame_ready = !pend_full_q;
  assign anode_n         = anode_n_q;
  assign sel_num         = sel_num_q;
  assign sel_pos         = sel_pos_q;
  assign frame_start     = frame_start_q;

endmodule
